// File: rtl/seq_pattern_counter.sv
// Serial bit-stream pattern detector with a run-time loadable pattern and a
// wrap/saturate match counter with a sticky overflow flag.
module seq_pattern_counter #(
    parameter int               PAT_W   = 4,
    parameter int               CNT_W   = 8,
    parameter logic [PAT_W-1:0] PAT_RST = 4'b1001,
    parameter bit               OVERLAP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             num_i,
    input  logic             load,
    input  logic [PAT_W-1:0] pattern_i,
    input  logic             sat_mode,
    input  logic             clr,
    output logic             detected,
    output logic [CNT_W-1:0] cnt,
    output logic             of
);

    localparam int               FILL_W    = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [PAT_W-1:0]  pat_q, pat_d;
    logic [PAT_W-1:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              of_q, of_d;
    logic              detected_q, detected_d;

    logic [PAT_W-1:0]  hist_n;
    logic [FILL_W-1:0] fill_n;
    logic              match;

    always_comb begin
        hist_n     = {hist_q[PAT_W-2:0], num_i};
        fill_n     = (fill_q == FILL_FULL) ? fill_q : fill_q + FILL_W'(1);
        match      = en && !load && (fill_n == FILL_FULL) && (hist_n == pat_q);

        pat_d      = pat_q;
        hist_d     = hist_q;
        fill_d     = fill_q;
        cnt_d      = cnt_q;
        of_d       = of_q;
        detected_d = match;

        // A load restarts history collection; the sampled bit is dropped.
        if (load) begin
            pat_d  = pattern_i;
            hist_d = '0;
            fill_d = '0;
        end else if (en) begin
            if (match && !OVERLAP) begin
                hist_d = '0;
                fill_d = '0;
            end else begin
                hist_d = hist_n;
                fill_d = fill_n;
            end
        end

        if (clr) begin
            cnt_d = '0;
            of_d  = 1'b0;
        end else if (match) begin
            if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
            end else begin
                cnt_d = sat_mode ? CNT_MAX : '0;
                of_d  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pat_q      <= PAT_RST;
            hist_q     <= '0;
            fill_q     <= '0;
            cnt_q      <= '0;
            of_q       <= 1'b0;
            detected_q <= 1'b0;
        end else begin
            pat_q      <= pat_d;
            hist_q     <= hist_d;
            fill_q     <= fill_d;
            cnt_q      <= cnt_d;
            of_q       <= of_d;
            detected_q <= detected_d;
        end
    end

    assign detected = detected_q;
    assign cnt      = cnt_q;
    assign of       = of_q;

endmodule

// File: tb/tb_seq_pattern_counter.sv
// Bench for seq_pattern_counter: three instances (default, non-overlap, 2-bit
// counter) driven in lockstep and compared against a queue-based reference model.
module tb_seq_pattern_counter;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, en, num_i, load, sat_mode, clr;
    logic [3:0] pattern_i;

    logic       det_a, det_b, det_c;
    logic [7:0] cnt_a, cnt_b;
    logic [1:0] cnt_c;
    logic       of_a, of_b, of_c;

    seq_pattern_counter #(.PAT_W(4), .CNT_W(8), .PAT_RST(4'b1001), .OVERLAP(1'b1)) u_a (
        .clk(clk), .rst(rst), .en(en), .num_i(num_i), .load(load), .pattern_i(pattern_i),
        .sat_mode(sat_mode), .clr(clr), .detected(det_a), .cnt(cnt_a), .of(of_a));

    seq_pattern_counter #(.PAT_W(4), .CNT_W(8), .PAT_RST(4'b1001), .OVERLAP(1'b0)) u_b (
        .clk(clk), .rst(rst), .en(en), .num_i(num_i), .load(load), .pattern_i(pattern_i),
        .sat_mode(sat_mode), .clr(clr), .detected(det_b), .cnt(cnt_b), .of(of_b));

    seq_pattern_counter #(.PAT_W(4), .CNT_W(2), .PAT_RST(4'b1001), .OVERLAP(1'b1)) u_c (
        .clk(clk), .rst(rst), .en(en), .num_i(num_i), .load(load), .pattern_i(pattern_i),
        .sat_mode(sat_mode), .clr(clr), .detected(det_c), .cnt(cnt_c), .of(of_c));

    int total = 0;
    int bad   = 0;

    // Reference model: accepted bits since the last restart, oldest first.
    bit         hq[3][$];
    int         m_cnt[3];
    bit         m_of[3];
    bit         m_det[3];
    logic [3:0] m_pat;
    int         cmax[3] = '{255, 255, 3};
    bit         ov[3]   = '{1'b1, 1'b0, 1'b1};
    bit         sat_g   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_step();
        bit m;
        if (rst) begin
            m_pat = 4'b1001;
            for (int k = 0; k < 3; k++) begin
                hq[k].delete();
                m_cnt[k] = 0;
                m_of[k]  = 1'b0;
                m_det[k] = 1'b0;
            end
        end else begin
            if (load) m_pat = pattern_i;
            for (int k = 0; k < 3; k++) begin
                m = 1'b0;
                if (load) begin
                    hq[k].delete();
                end else if (en) begin
                    hq[k].push_back(num_i);
                    if (hq[k].size() > 4) void'(hq[k].pop_front());
                    if (hq[k].size() == 4) begin
                        m = 1'b1;
                        for (int i = 0; i < 4; i++)
                            if (hq[k][i] != m_pat[3-i]) m = 1'b0;
                    end
                    if (m && !ov[k]) hq[k].delete();
                end
                m_det[k] = m;
                if (clr) begin
                    m_cnt[k] = 0;
                    m_of[k]  = 1'b0;
                end else if (m) begin
                    if (m_cnt[k] == cmax[k]) begin
                        m_of[k]  = 1'b1;
                        m_cnt[k] = sat_mode ? cmax[k] : 0;
                    end else begin
                        m_cnt[k] = m_cnt[k] + 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all();
        chk("det_a", 32'(det_a), 32'(m_det[0]));
        chk("cnt_a", 32'(cnt_a), 32'(m_cnt[0]));
        chk("of_a",  32'(of_a),  32'(m_of[0]));
        chk("det_b", 32'(det_b), 32'(m_det[1]));
        chk("cnt_b", 32'(cnt_b), 32'(m_cnt[1]));
        chk("of_b",  32'(of_b),  32'(m_of[1]));
        chk("det_c", 32'(det_c), 32'(m_det[2]));
        chk("cnt_c", 32'(cnt_c), 32'(m_cnt[2]));
        chk("of_c",  32'(of_c),  32'(m_of[2]));
    endtask

    task automatic step(input bit r, input bit e, input bit n, input bit l,
                        input logic [3:0] p, input bit s, input bit c);
        rst = r; en = e; num_i = n; load = l; pattern_i = p; sat_mode = s; clr = c;
        model_step();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic send(input logic [15:0] v, input int n);
        logic [15:0] t;
        t = v;
        for (int i = n - 1; i >= 0; i--)
            step(1'b0, 1'b1, t[i], 1'b0, 4'h0, sat_g, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 1'b0, 1'b0, 4'h0, sat_g, 1'b0);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; num_i = 1'b0; load = 1'b0;
        pattern_i = 4'h0; sat_mode = 1'b0; clr = 1'b0;

        // Reset state.
        do_reset();
        do_reset();
        chk("rst_cnt_a", 32'(cnt_a), 32'd0);
        chk("rst_det_a", 32'(det_a), 32'd0);

        // Overlap vs non-overlap on 1001001, then 1001 more.
        send(16'b1001001, 7);
        chk("ovl_cnt_a", 32'(cnt_a), 32'd2);
        chk("novl_cnt_b", 32'(cnt_b), 32'd1);
        send(16'b1001, 4);
        chk("novl_cnt_b2", 32'(cnt_b), 32'd2);

        // 2-bit counter: wrap, then saturate.
        sat_g = 1'b0;
        do_reset();
        send(16'b1001, 4);
        for (int i = 0; i < 3; i++) send(16'b001, 3);
        chk("wrap_cnt_c", 32'(cnt_c), 32'd0);
        chk("wrap_of_c", 32'(of_c), 32'd1);
        sat_g = 1'b1;
        do_reset();
        send(16'b1001, 4);
        for (int i = 0; i < 4; i++) send(16'b001, 3);
        chk("sat_cnt_c", 32'(cnt_c), 32'd3);
        chk("sat_of_c", 32'(of_c), 32'd1);
        sat_g = 1'b0;

        // Load discards a partial, new pattern matches, old one does not.
        do_reset();
        send(16'b100, 3);
        step(1'b0, 1'b1, 1'b1, 1'b1, 4'b1100, sat_g, 1'b0);
        send(16'b1100, 4);
        chk("load_cnt_a", 32'(cnt_a), 32'd1);
        send(16'b1001, 4);
        chk("load_old_cnt_a", 32'(cnt_a), 32'd1);

        // en toggled low between bits; held cycles ignored.
        do_reset();
        for (int i = 3; i >= 0; i--) begin
            step(1'b0, 1'b1, 1'((4'b1001 >> i) & 1), 1'b0, 4'h0, sat_g, 1'b0);
            if (i != 0) step(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0, 4'h0, sat_g, 1'b0);
        end
        chk("en_det_a", 32'(det_a), 32'd1);
        chk("en_cnt_a", 32'(cnt_a), 32'd1);

        // clr wins over a same-edge increment, then rst mid-pattern.
        do_reset();
        send(16'b1001, 4);
        for (int i = 0; i < 260; i++) send(16'b001, 3);
        chk("pre_clr_cnt_a", 32'(cnt_a), 32'd5);
        chk("pre_clr_of_a", 32'(of_a), 32'd1);
        send(16'b00, 2);
        step(1'b0, 1'b1, 1'b1, 1'b0, 4'h0, sat_g, 1'b1);
        chk("clr_det_a", 32'(det_a), 32'd1);
        chk("clr_cnt_a", 32'(cnt_a), 32'd0);
        chk("clr_of_a", 32'(of_a), 32'd0);
        send(16'b100, 3);
        do_reset();
        send(16'b1, 1);
        chk("rst_mid_det_a", 32'(det_a), 32'd0);
        chk("rst_mid_cnt_a", 32'(cnt_a), 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 199) == 0) sat_g = ~sat_g;
            step(($urandom_range(0, 99) == 0),
                 ($urandom_range(0, 9) < 8),
                 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 49) == 0),
                 4'($urandom_range(0, 15)),
                 sat_g,
                 ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/seq_pattern_counter.md
Name: seq_pattern_counter

Overview:
- Serial bit-stream pattern detector with occurrence counter; successor to the fixed 4-bit "1001" detector/counter.
- Pattern width, pattern value and counter width are parameters, and the pattern can be reloaded at run time.
- Adds: input enable, overlapping/non-overlapping match mode, wrap/saturate counter mode, counter clear, per-match pulse output.
- Sits after a serial data input, ahead of status/readout logic.

Parameters:
PAT_W, 4, pattern length in bits (>=2)
CNT_W, 8, match counter width (>=2)
PAT_RST, 4'b1001, pattern loaded at reset (PAT_W bits)
OVERLAP, 1, 1 = overlapping matches allowed; 0 = history discarded after each match

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
en  input  1  accept num_i this cycle
num_i  input  1  serial data bit
load  input  1  load pattern_i into pattern register
pattern_i  input  PAT_W  new pattern; MSB is the first bit received
sat_mode  input  1  0 = counter wraps, 1 = counter saturates
clr  input  1  clear cnt and of
detected  output  1  one-cycle pulse per match (registered)
cnt  output  CNT_W  match count
of  output  1  sticky overflow flag

Behaviour:
- Reset (rst=1 at clk edge): pat_reg<=PAT_RST, hist<=0, fill<=0, cnt<=0, of<=0, detected<=0. Reset overrides all other inputs.
- State:
  - hist: PAT_W-bit shift register; newest bit in LSB.
  - fill: count of valid history bits, 0..PAT_W, saturating at PAT_W.
  - pat_reg: PAT_W-bit current pattern.
- Accept: at an edge with en=1 and load=0:
  - hist_n = {hist[PAT_W-2:0], num_i}; fill_n = min(fill+1, PAT_W).
  - match = (fill_n==PAT_W) && (hist_n==pat_reg).
- en=0 with load=0: hist, fill and pat_reg hold; no match; detected<=0.
- Load (load=1): pat_reg<=pattern_i, hist<=0, fill<=0. num_i is ignored that cycle even if en=1. No match; detected<=0. cnt and of are unaffected.
- Match handling, all at the same edge:
  - detected<=1. Latency: detected and the updated cnt are visible the cycle after the edge that sampled the last pattern bit.
  - OVERLAP=1: hist<=hist_n, fill<=PAT_W, so a suffix can start the next match (e.g. 1001001 gives 2 matches).
  - OVERLAP=0: hist<=0, fill<=0 (1001001 gives 1 match; 10011001 gives 2).
- Counter on match:
  - cnt < 2^CNT_W-1: cnt<=cnt+1.
  - cnt == max and sat_mode=0: cnt<=0, of<=1.
  - cnt == max and sat_mode=1: cnt holds max, of<=1.
  - of is sticky until clr or rst.
- clr=1: cnt<=0, of<=0. clr wins over a same-cycle increment. The match itself is still recognised: detected still pulses and hist/fill update normally.
- sat_mode is sampled every cycle; changing it mid-run affects only later overflow events.
- No match is possible until PAT_W bits have been accepted since reset, load, or a non-overlap match.
- Mid-stream rst or load discards a partial pattern; the next match needs a full PAT_W fresh bits.
- detected is 0 in every cycle that is not the cycle after a match edge.

Test Plan:
- Defaults, en=1, stream 1,0,0,1,0,0,1 -> detected pulses after bits 4 and 7; cnt=2; of=0.
- OVERLAP=0 instance, same stream 1001001 -> one pulse after bit 4; cnt=1. Then stream 1001 -> cnt=2.
- CNT_W=2, sat_mode=0, 4 matches -> cnt 1,2,3,0; of=1 after the 4th. Repeat with sat_mode=1 -> cnt stays 3, of=1.
- load=1 with pattern_i=4'b1100 midway through a partial 100 -> partial discarded. Then 1,1,0,0 -> one pulse. Then 1,0,0,1 -> no pulse.
- en toggled low between each bit of 1001 -> held cycles ignored; exactly one pulse after the 4th accepted bit.
- clr asserted on the same edge as a match with cnt=5, of=1 -> detected=1, cnt=0, of=0. Then rst mid-pattern (after 100), then 1 -> no pulse; all outputs 0.
